// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and state type for the load/store unit
package lsu_pkg;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_e;

  // 011, 110 and 111 have no access size and always fault
  function automatic logic f3_reserved(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores, load extract/extend, fault detect
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        fault_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    fault_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        fault_o = addr_lo_i[0];
      end
      default: begin
        be_o    = 4'b1111;
        fault_o = |addr_lo_i;
      end
    endcase
    if (f3_reserved(funct3_i)) fault_o = 1'b1;
  end

  // Halfword lanes only ever start at 0 or 2, so one shift covers both sizes
  always_comb begin
    shifted = rdata_i >> {ld_addr_lo_i, 3'b000};
    case (ld_funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_o = {24'h000000, shifted[7:0]};
      F3_HU:   rdata_o = {16'h0000, shifted[15:0]};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit: IDLE/BUSY/DONE bus handshake
// with stall generation, misalignment faults and a bus timeout.
module load_store_unit import lsu_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = LSU_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic                  req_q, we_q, buserr_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, result_q;
  logic [3:0]            be_q;
  logic [2:0]            f3_q;
  logic [1:0]            addr_lo_q;

  logic                  access, fault, legal;
  logic [3:0]            be_n;
  logic [DATA_WIDTH-1:0] wdata_n, ld_data;

  lsu_align u_align (
    .funct3_i     (Funct3M),
    .addr_lo_i    (ALUResultM[1:0]),
    .wdata_i      (WriteDataM),
    .be_o         (be_n),
    .wdata_o      (wdata_n),
    .fault_o      (fault),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (addr_lo_q),
    .rdata_i      (mem_rdata),
    .rdata_o      (ld_data)
  );

  assign access    = MemReadM | MemWriteM;
  assign legal     = (state_q == IDLE) && access && !fault;
  assign StallM    = legal || (state_q == BUSY);
  assign MisalignM = (state_q == IDLE) && access && fault;

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign ReadDataM = result_q;
  assign BusErrM   = buserr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      buserr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      be_q      <= 4'b0000;
      f3_q      <= 3'b000;
      addr_lo_q <= 2'b00;
    end else begin
      buserr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (legal) begin
            state_q   <= BUSY;
            req_q     <= 1'b1;
            we_q      <= MemWriteM;
            addr_q    <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            addr_lo_q <= ALUResultM[1:0];
            be_q      <= be_n;
            wdata_q   <= wdata_n;
            f3_q      <= Funct3M;
            cnt_q     <= '0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            if (!we_q) result_q <= ld_data;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Abort: the result register reads back as zero alongside the error pulse
            state_q  <= DONE;
            req_q    <= 1'b0;
            cnt_q    <= '0;
            buserr_q <= 1'b1;
            result_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit (TIMEOUT=8)
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b000;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
    .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        we;
    int          stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          ob_stall, ob_req;
  logic [31:0] ob_addr, ob_wdata, ob_rdata;
  logic [3:0]  ob_be;
  logic        ob_we, ob_buserr, ob_misalign, ob_done, ob_req_in_done;

  // Drives one access and records what the DUT did; ack arrives in BUSY cycle ack_at (0 = never)
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ack_at);
    bit prev_stall;
    ob_stall = 0; ob_req = 0; ob_addr = '0; ob_wdata = '0; ob_rdata = '0; ob_be = '0;
    ob_we = 0; ob_buserr = 0; ob_misalign = 0; ob_done = 0; ob_req_in_done = 0;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    mem_rdata = rdata; mem_ack = 1'b0;
    @(negedge clk);
    ob_misalign = MisalignM;
    prev_stall  = StallM;
    if (StallM) ob_stall++;
    if (mem_req) ob_req++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      MemReadM = 1'b0; MemWriteM = 1'b0;
      mem_ack = (c == ack_at);
      @(negedge clk);
      if (StallM) ob_stall++;
      if (mem_req) begin
        ob_req++; ob_addr = mem_addr; ob_wdata = mem_wdata; ob_be = mem_be; ob_we = mem_we;
      end
      if (prev_stall && !StallM) begin
        ob_done = 1; ob_rdata = ReadDataM; ob_buserr = BusErrM; ob_req_in_done = mem_req;
        break;
      end
      if (!prev_stall && !StallM && c >= 4) break;
      prev_stall = StallM;
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadDataM, StallM, MisalignM, BusErrM} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h be=%b rd=%h stall=%b mis=%b berr=%b, all required 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadDataM, StallM, MisalignM, BusErrM);
    end
  endtask

  task automatic test_store_word;
    exp_t e;
    sb_q.push_back('{32'h104, 32'hDEADBEEF, 32'h0, 4'b1111, 1'b1, 2});
    run_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1);
    e = sb_q.pop_front();
    n_tests++; if (ob_done !== 1'b1) begin n_fail++; $display("FAIL sw_done: got %b expected 1", ob_done); end
    n_tests++; if (ob_addr !== e.addr) begin n_fail++; $display("FAIL sw_addr: got %h expected %h", ob_addr, e.addr); end
    n_tests++; if (ob_be !== e.be) begin n_fail++; $display("FAIL sw_be: got %b expected %b", ob_be, e.be); end
    n_tests++; if (ob_wdata !== e.wdata) begin n_fail++; $display("FAIL sw_wdata: got %h expected %h", ob_wdata, e.wdata); end
    n_tests++; if (ob_we !== e.we) begin n_fail++; $display("FAIL sw_we: got %b expected %b", ob_we, e.we); end
    n_tests++; if (ob_stall != e.stall) begin n_fail++; $display("FAIL sw_stall: got %0d expected %0d", ob_stall, e.stall); end
    n_tests++; if (ob_req_in_done !== 1'b0) begin n_fail++; $display("FAIL sw_req_done: got %b expected 0", ob_req_in_done); end
  endtask

  task automatic test_load_byte;
    exp_t e;
    sb_q.push_back('{32'h200, 32'h0, 32'hFFFFFF80, 4'b1000, 1'b0, 4});
    sb_q.push_back('{32'h200, 32'h0, 32'h00000080, 4'b1000, 1'b0, 4});
    run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF0011, 3);
    e = sb_q.pop_front();
    n_tests++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL lb_data: got %h expected %h", ob_rdata, e.rdata); end
    n_tests++; if (ob_stall != e.stall) begin n_fail++; $display("FAIL lb_stall: got %0d expected %0d", ob_stall, e.stall); end
    n_tests++; if (ob_addr !== e.addr) begin n_fail++; $display("FAIL lb_addr: got %h expected %h", ob_addr, e.addr); end
    n_tests++; if (ob_we !== e.we) begin n_fail++; $display("FAIL lb_we: got %b expected %b", ob_we, e.we); end
    run_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF0011, 3);
    e = sb_q.pop_front();
    n_tests++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL lbu_data: got %h expected %h", ob_rdata, e.rdata); end
    n_tests++; if (ob_stall != e.stall) begin n_fail++; $display("FAIL lbu_stall: got %0d expected %0d", ob_stall, e.stall); end
    @(negedge clk);
    n_tests++; if (ReadDataM !== e.rdata) begin n_fail++; $display("FAIL lbu_hold: got %h expected %h", ReadDataM, e.rdata); end
  endtask

  task automatic test_reset_busy;
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300;
    @(posedge clk); #1;
    MemReadM = 1'b0;
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rb_req_busy: got %b expected 1", mem_req); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadDataM, StallM, MisalignM, BusErrM} !== '0) begin
      n_fail++;
      $display("FAIL rb_outputs: req=%b addr=%h be=%b rd=%h stall=%b, all required 0",
               mem_req, mem_addr, mem_be, ReadDataM, StallM);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_tests++; if (ReadDataM !== 32'h0) begin n_fail++; $display("FAIL rb_stray_ack_data: got %h expected 0", ReadDataM); end
    n_tests++; if (mem_req !== 1'b0 || StallM !== 1'b0) begin
      n_fail++; $display("FAIL rb_stray_ack_state: req=%b stall=%b expected 0 0", mem_req, StallM);
    end
  endtask

  task automatic test_store_half;
    exp_t e;
    sb_q.push_back('{32'h100, 32'h12341234, 32'h0, 4'b1100, 1'b1, 2});
    sb_q.push_back('{32'h100, 32'hABABABAB, 32'h0, 4'b0010, 1'b1, 3});
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 1);
    e = sb_q.pop_front();
    n_tests++; if (ob_be !== e.be) begin n_fail++; $display("FAIL sh_be: got %b expected %b", ob_be, e.be); end
    n_tests++; if (ob_wdata !== e.wdata) begin n_fail++; $display("FAIL sh_wdata: got %h expected %h", ob_wdata, e.wdata); end
    n_tests++; if (ob_addr !== e.addr) begin n_fail++; $display("FAIL sh_addr: got %h expected %h", ob_addr, e.addr); end
    run_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 2);
    e = sb_q.pop_front();
    n_tests++; if (ob_be !== e.be) begin n_fail++; $display("FAIL sb_be: got %b expected %b", ob_be, e.be); end
    n_tests++; if (ob_wdata !== e.wdata) begin n_fail++; $display("FAIL sb_wdata: got %h expected %h", ob_wdata, e.wdata); end
    n_tests++; if (ob_stall != e.stall) begin n_fail++; $display("FAIL sb_stall: got %0d expected %0d", ob_stall, e.stall); end
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
    n_tests++; if (ob_misalign !== 1'b1) begin n_fail++; $display("FAIL lw_mis_pulse: got %b expected 1", ob_misalign); end
    n_tests++; if (ob_req != 0) begin n_fail++; $display("FAIL lw_mis_req: got %0d req cycles expected 0", ob_req); end
    n_tests++; if (ob_stall != 0) begin n_fail++; $display("FAIL lw_mis_stall: got %0d expected 0", ob_stall); end
    n_tests++; if (MisalignM !== 1'b0) begin n_fail++; $display("FAIL lw_mis_one_cycle: got %b expected 0", MisalignM); end
  endtask

  task automatic test_timeout;
    run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hFFFFFFFF, 0);
    n_tests++; if (ob_done !== 1'b1) begin n_fail++; $display("FAIL to_done: got %b expected 1", ob_done); end
    n_tests++; if (ob_req != TO) begin n_fail++; $display("FAIL to_req_cycles: got %0d expected %0d", ob_req, TO); end
    n_tests++; if (ob_buserr !== 1'b1) begin n_fail++; $display("FAIL to_buserr: got %b expected 1", ob_buserr); end
    n_tests++; if (ob_rdata !== 32'h0) begin n_fail++; $display("FAIL to_data: got %h expected 0", ob_rdata); end
    @(negedge clk);
    n_tests++; if (BusErrM !== 1'b0) begin n_fail++; $display("FAIL to_buserr_pulse: got %b expected 0", BusErrM); end
  endtask

  task automatic test_both_set;
    exp_t e;
    sb_q.push_back('{32'h10, 32'h00000055, 32'h0, 4'b1111, 1'b1, 2});
    run_access(1'b1, 1'b1, 3'b010, 32'h10, 32'h00000055, 32'h0, 1);
    e = sb_q.pop_front();
    n_tests++; if (ob_we !== e.we) begin n_fail++; $display("FAIL both_we: got %b expected %b", ob_we, e.we); end
    n_tests++; if (ob_wdata !== e.wdata) begin n_fail++; $display("FAIL both_wdata: got %h expected %h", ob_wdata, e.wdata); end
    run_access(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1);
    n_tests++; if (ob_misalign !== 1'b1) begin n_fail++; $display("FAIL f3_011_mis: got %b expected 1", ob_misalign); end
    n_tests++; if (ob_req != 0) begin n_fail++; $display("FAIL f3_011_req: got %0d expected 0", ob_req); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    sb_q.push_back('{32'h200, 32'h0, 32'hFFFF8001, 4'b1100, 1'b0, 2});
    sb_q.push_back('{32'h200, 32'h0, 32'h0000F00D, 4'b0011, 1'b0, 2});
    sb_q.push_back('{32'h300, 32'h0, 32'hCAFEBABE, 4'b1111, 1'b0, 3});
    run_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80011234, 1);
    e = sb_q.pop_front();
    n_tests++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL lh_data: got %h expected %h", ob_rdata, e.rdata); end
    n_tests++; if (ob_be !== e.be) begin n_fail++; $display("FAIL lh_be: got %b expected %b", ob_be, e.be); end
    run_access(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 32'h1234F00D, 1);
    e = sb_q.pop_front();
    n_tests++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL lhu_data: got %h expected %h", ob_rdata, e.rdata); end
    run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEBABE, 2);
    e = sb_q.pop_front();
    n_tests++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL lw_data: got %h expected %h", ob_rdata, e.rdata); end
    n_tests++; if (ob_stall != e.stall) begin n_fail++; $display("FAIL lw_stall: got %0d expected %0d", ob_stall, e.stall); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_reset_busy();
    test_store_half();
    test_timeout();
    test_both_set();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data/address width; only 32 is supported.
REQ-002 Parameter TIMEOUT, default 255: maximum BUSY cycles without mem_ack before abort.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 MemReadM  in  1  load present in memory stage.
REQ-006 MemWriteM  in  1  store present in memory stage.
REQ-007 Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ALUResultM  in  32  byte address.
REQ-009 WriteDataM  in  32  store data, right-aligned.
REQ-010 mem_req  out  1  bus request; held until mem_ack.
REQ-011 mem_we  out  1  1 = write.
REQ-012 mem_addr  out  32  word address, {ALUResultM[31:2],2'b00}.
REQ-013 mem_wdata  out  32  lane-shifted store data.
REQ-014 mem_be  out  4  byte enables.
REQ-015 mem_ack  in  1  one-cycle completion strobe.
REQ-016 mem_rdata  in  32  read word, valid with mem_ack.
REQ-017 ReadDataM  out  32  extended load result.
REQ-018 StallM  out  1  freeze PC/IF/ID/EX and EX/MEM register.
REQ-019 MisalignM  out  1  one-cycle misaligned/reserved-funct3 fault.
REQ-020 BusErrM  out  1  one-cycle timeout fault.

Function
REQ-021 FSM states IDLE, BUSY, DONE; access = MemReadM | MemWriteM; both asserted is treated as a write.
REQ-022 Alignment: H/HU need addr[0]=0; W needs addr[1:0]=0; funct3 011/110/111 is always a fault.
REQ-023 IDLE with faulting access: MisalignM=1 in that cycle, no bus request, StallM=0, state stays IDLE.
REQ-024 IDLE with legal access: StallM=1 combinationally; next state BUSY; address, be, wdata, we, and funct3 are latched.
REQ-025 BUSY: mem_req=1 with latched values stable; StallM=1; timeout counter increments each cycle.
REQ-026 BUSY with mem_ack: load captures mem_rdata into the result register; next state DONE; counter clears.
REQ-027 BUSY with counter reaching TIMEOUT and no ack: mem_req drops; BusErrM=1 in DONE; ReadDataM=0; next state DONE.
REQ-028 DONE: StallM=0, mem_req=0, ReadDataM valid for this cycle only; next state IDLE unconditionally.
REQ-029 Minimum access latency is 2 stall cycles (IDLE, BUSY with ack), then DONE.
REQ-030 Store be: B = 4'b0001<<addr[1:0]; H = addr[1]?4'b1100:4'b0011; W = 4'b1111.
REQ-031 Store wdata: B replicates byte[7:0] to all lanes; H replicates half[15:0] to both halves; W is passed through.
REQ-032 Load extract: select lane by latched addr[1:0]; B/H sign-extend; BU/HU zero-extend; W is passed through.
REQ-033 mem_ack outside BUSY is ignored; mem_rdata is sampled only on ack of a read.
REQ-034 ReadDataM holds its last value outside DONE.

Reset
REQ-035 rst has priority over all events: next state IDLE, counter 0, result register 0.
REQ-036 In the cycle after rst, all outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadDataM, StallM, MisalignM, BusErrM.
REQ-037 rst asserted during BUSY drops mem_req the next cycle; a later stray mem_ack is ignored.

Structure
REQ-038 Package lsu_pkg holds the funct3 encodings, the state enum (IDLE, BUSY, DONE), and the TIMEOUT default.
REQ-039 Sub-module lsu_align is purely combinational: be/wdata generation, load extract/extension, and fault detect.
REQ-040 The FSM, latches, and counter reside in load_store_unit.

Verification
REQ-041 Sub-test 1: SW addr 0x104, data 0xDEADBEEF, ack in the 1st BUSY cycle -> mem_addr 0x104, be 1111, StallM high 2 cycles, then DONE.
REQ-042 Sub-test 2: LB addr 0x203, rdata 0x80FF0011, ack after 3 cycles -> ReadDataM 0xFFFFFF80; LBU on the same data -> 0x00000080; StallM high 4 cycles.
REQ-043 Sub-test 3: SH addr 0x102, data 0x1234 -> be 1100, wdata 0x12341234; LW addr 0x101 -> MisalignM 1 cycle, mem_req never rises, StallM 0.
REQ-044 Sub-test 4: load with no ack and TIMEOUT=8 -> mem_req high 8 cycles, BusErrM pulse in DONE, ReadDataM 0.
REQ-045 Sub-test 5: rst in the 2nd BUSY cycle, then ack -> state IDLE, all outputs 0, ack ignored.
REQ-046 Sub-test 6: MemReadM and MemWriteM both set -> mem_we 1; funct3 011 -> MisalignM pulse.
